// File: rtl/inst_ram_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes
// them through the instruction-RAM debug port, then releases the CPU from reset.
module inst_ram_loader #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned MAX_WORDS  = 1024,
   parameter int unsigned RST_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        debug,
   output logic        inst_ram_write_enable,
   output logic [31:0] inst_ram_write_data,
   output logic [31:0] inst_ram_write_address,
   output logic        cpu_reset,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_WRITE,
      S_RST,
      S_RUN,
      S_ERR
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [1:0]  byte_cnt;
   logic [23:0] asm_reg;
   logic [31:0] asm_full;
   logic [31:0] len_reg;
   logic [31:0] word_cnt;
   logic [31:0] rst_cnt;
   logic        xfer;
   logic        last_byte;
   logic        start_ok;

   assign in_ready  = (state == S_LEN) || (state == S_DATA);
   assign busy      = (state == S_LEN) || (state == S_DATA) ||
                      (state == S_WRITE) || (state == S_RST);
   assign xfer      = in_valid && in_ready;
   assign last_byte = xfer && (byte_cnt == 2'd3);
   assign start_ok  = start && ((state == S_IDLE) || (state == S_RUN) || (state == S_ERR));
   // The fourth byte of a group is used directly so decisions happen on its edge
   assign asm_full  = {in_data, asm_reg};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (start) next_state = S_LEN;
         end
         S_LEN: begin
            if (last_byte) begin
               if (asm_full == 32'd0)          next_state = S_RST;
               else if (asm_full > MAX_WORDS)  next_state = S_ERR;
               else                            next_state = S_DATA;
            end
         end
         S_DATA: begin
            if (last_byte) next_state = S_WRITE;
         end
         S_WRITE: begin
            next_state = ((word_cnt + 32'd1) == len_reg) ? S_RST : S_DATA;
         end
         S_RST: begin
            if (rst_cnt == (RST_CYCLES - 1)) next_state = S_RUN;
         end
         S_RUN, S_ERR: begin
            if (start) next_state = S_LEN;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Status outputs are registered from the upcoming state so they line up with it
   always_ff @(posedge clk) begin
      if (!reset) begin
         debug                  <= 1'b0;
         inst_ram_write_enable  <= 1'b0;
         inst_ram_write_data    <= 32'd0;
         inst_ram_write_address <= BASE_ADDR;
         cpu_reset              <= 1'b1;
         done                   <= 1'b0;
         error                  <= 1'b0;
         byte_cnt               <= 2'd0;
         asm_reg                <= 24'd0;
         len_reg                <= 32'd0;
         word_cnt               <= 32'd0;
         rst_cnt                <= 32'd0;
      end else begin
         debug                 <= next_state inside {S_LEN, S_DATA, S_WRITE};
         inst_ram_write_enable <= (next_state == S_WRITE);
         cpu_reset             <= (next_state != S_RUN);
         done                  <= (next_state == S_RUN);
         error                 <= (next_state == S_ERR);
         rst_cnt               <= (state == S_RST) ? rst_cnt + 32'd1 : 32'd0;
         if (start_ok) begin
            byte_cnt               <= 2'd0;
            asm_reg                <= 24'd0;
            len_reg                <= 32'd0;
            word_cnt               <= 32'd0;
            inst_ram_write_address <= BASE_ADDR;
         end else begin
            if (xfer) begin
               byte_cnt <= byte_cnt + 2'd1;
               case (byte_cnt)
                  2'd0:    asm_reg[7:0]   <= in_data;
                  2'd1:    asm_reg[15:8]  <= in_data;
                  2'd2:    asm_reg[23:16] <= in_data;
                  default: ;
               endcase
            end
            if ((state == S_LEN) && last_byte) len_reg <= asm_full;
            if ((state == S_DATA) && last_byte) inst_ram_write_data <= asm_full;
            if (state == S_WRITE) begin
               inst_ram_write_address <= inst_ram_write_address + 32'd4;
               word_cnt               <= word_cnt + 32'd1;
            end
         end
      end
   end

endmodule
